// File: rtl/span_pkg.sv
// Shared types and constants for the position netting loader and its
// saturating adder: table slot layout, quantity limits and FSM states.
package span_pkg;

    localparam int SLOTS = 8;
    localparam int QTY_W = 16;
    localparam int MAT_W = 8;

    typedef logic signed [QTY_W-1:0] qty_t;
    typedef logic [MAT_W-1:0]        mat_t;

    typedef struct packed {
        logic occupied;
        mat_t mat;
        qty_t qty;
    } slot_t;

    // Symmetric clamp so the downstream negate of any stored value still fits.
    localparam qty_t QTY_SAT_MAX = 16'h7FFF;
    localparam qty_t QTY_SAT_MIN = 16'h8001;

    typedef enum logic [1:0] {
        COLLECT,
        PRESENT,
        CLEAR
    } state_t;

endpackage

// File: rtl/span_sat_add.sv
// Combinational signed saturating adder; clamps to the symmetric range
// [QTY_SAT_MIN, QTY_SAT_MAX] and flags any clamp.
module span_sat_add
    import span_pkg::*;
(
    input  qty_t a,
    input  qty_t b,
    output qty_t sum,
    output logic sat
);

    localparam logic signed [QTY_W:0] WIDE_MAX = {1'b0, QTY_SAT_MAX};
    localparam logic signed [QTY_W:0] WIDE_MIN = {1'b1, QTY_SAT_MIN};

    logic signed [QTY_W:0] wide;

    always_comb begin
        wide = {a[QTY_W-1], a} + {b[QTY_W-1], b};
        sum  = wide[QTY_W-1:0];
        sat  = 1'b0;
        if (wide > WIDE_MAX) begin
            sum = QTY_SAT_MAX;
            sat = 1'b1;
        end else if (wide < WIDE_MIN) begin
            sum = QTY_SAT_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/position_netting_loader.sv
// Nets a serial stream of trade records into a table of maturity slots and
// presents the table as a held parallel frame followed by a zero frame.
module position_netting_loader
    import span_pkg::*;
#(
    parameter int HOLD_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trade_valid,
    output logic                         trade_ready,
    input  logic [MAT_W-1:0]             trade_maturity,
    input  logic [QTY_W-1:0]             trade_qty,
    input  logic                         trade_last,
    output logic [SLOTS-1:0][QTY_W-1:0]  position,
    output logic [SLOTS-1:0][MAT_W-1:0]  maturity,
    output logic                         frame_valid,
    output logic                         err_full,
    output logic                         err_sat
);

    localparam int IDX_W  = $clog2(SLOTS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t             state;
    state_t             next_state;
    slot_t              slots     [SLOTS];
    slot_t              slots_new [SLOTS];
    logic               hit;
    logic               free_found;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   free_idx;
    qty_t               add_a;
    qty_t               add_sum;
    logic               add_sat;
    logic               accept;
    logic               hold_done;
    logic               full_new;
    logic               sat_new;
    logic [HOLD_W-1:0]  hold_count;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slots[i].occupied && (slots[i].mat == trade_maturity)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!slots[i].occupied) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // A freshly allocated slot goes through the adder with a zero base.
    assign add_a = hit ? slots[hit_idx].qty : '0;

    span_sat_add u_sat_add (
        .a   (add_a),
        .b   (trade_qty),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_comb begin
        slots_new = slots;
        full_new  = err_full;
        sat_new   = err_sat;
        if (hit) begin
            slots_new[hit_idx].qty = add_sum;
            sat_new                = err_sat | add_sat;
        end else if (free_found) begin
            slots_new[free_idx].occupied = 1'b1;
            slots_new[free_idx].mat      = trade_maturity;
            slots_new[free_idx].qty      = add_sum;
            sat_new                      = err_sat | add_sat;
        end else begin
            full_new = 1'b1;
        end
    end

    assign hold_done = (hold_count == HOLD_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (accept && trade_last) next_state = PRESENT;
            PRESENT: if (hold_done)            next_state = CLEAR;
            CLEAR:                             next_state = COLLECT;
            default:                           next_state = COLLECT;
        endcase
    end

    always_comb begin
        trade_ready = (state == COLLECT);
        accept      = trade_valid && trade_ready;
    end

    // Leaving PRESENT wipes table, outputs and errors so CLEAR shows a zero frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots[i] <= '0;
            end
            position    <= '0;
            maturity    <= '0;
            frame_valid <= 1'b0;
            err_full    <= 1'b0;
            err_sat     <= 1'b0;
            hold_count  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        slots    <= slots_new;
                        err_full <= full_new;
                        err_sat  <= sat_new;
                        if (trade_last) begin
                            for (int i = 0; i < SLOTS; i++) begin
                                position[i] <= slots_new[i].occupied ? slots_new[i].qty : '0;
                                maturity[i] <= slots_new[i].occupied ? slots_new[i].mat : '0;
                            end
                            frame_valid <= 1'b1;
                            hold_count  <= '0;
                        end
                    end
                end
                PRESENT: begin
                    if (hold_done) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            slots[i] <= '0;
                        end
                        position    <= '0;
                        maturity    <= '0;
                        frame_valid <= 1'b0;
                        err_full    <= 1'b0;
                        err_sat     <= 1'b0;
                        hold_count  <= '0;
                    end else begin
                        hold_count <= hold_count + 1'b1;
                    end
                end
                CLEAR: begin
                    hold_count <= '0;
                end
                default: begin
                    hold_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_position_netting_loader.sv
// Self-checking bench: table of portfolios with hand-computed frames fed to a
// scoreboard queue, plus backpressure and asynchronous reset sequences.
module tb_position_netting_loader;
    import span_pkg::*;

    localparam int HOLD = 8;

    typedef struct {
        string                        name;
        int                           n;
        logic [8:0][MAT_W-1:0]        tm;
        logic [8:0][QTY_W-1:0]        tq;
        logic [SLOTS-1:0][QTY_W-1:0]  epos;
        logic [SLOTS-1:0][MAT_W-1:0]  emat;
        logic                         eful;
        logic                         esat;
    } vec_t;

    logic                         clk;
    logic                         reset;
    logic                         trade_valid;
    logic                         trade_ready;
    logic [MAT_W-1:0]             trade_maturity;
    logic [QTY_W-1:0]             trade_qty;
    logic                         trade_last;
    logic [SLOTS-1:0][QTY_W-1:0]  position;
    logic [SLOTS-1:0][MAT_W-1:0]  maturity;
    logic                         frame_valid;
    logic                         err_full;
    logic                         err_sat;

    vec_t vecs [9];
    vec_t exp_q [$];
    vec_t cur;
    int   checks = 0;
    int   failures = 0;
    int   hold_len = 0;
    logic stable_ok = 1'b1;
    logic prev_fv = 1'b0;
    logic skip_fall = 1'b0;

    position_netting_loader #(.HOLD_CYCLES(HOLD)) dut (
        .clk            (clk),
        .reset          (reset),
        .trade_valid    (trade_valid),
        .trade_ready    (trade_ready),
        .trade_maturity (trade_maturity),
        .trade_qty      (trade_qty),
        .trade_last     (trade_last),
        .position       (position),
        .maturity       (maturity),
        .frame_valid    (frame_valid),
        .err_full       (err_full),
        .err_sat        (err_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t blank(input string nm);
        vec_t v;
        v.name = nm;
        v.n    = 0;
        v.tm   = '0;
        v.tq   = '0;
        v.epos = '0;
        v.emat = '0;
        v.eful = 1'b0;
        v.esat = 1'b0;
        return v;
    endfunction

    function automatic vec_t add(input vec_t v, input logic [MAT_W-1:0] m, input logic [QTY_W-1:0] q);
        vec_t r = v;
        r.tm[r.n] = m;
        r.tq[r.n] = q;
        r.n       = r.n + 1;
        return r;
    endfunction

    // Drives one portfolio back-to-back; returns the stall count of its first record.
    task automatic applyStimulus(input int c, output int stall);
        stall = 0;
        for (int i = 0; i < vecs[c].n; i++) begin
            trade_valid    = 1'b1;
            trade_maturity = vecs[c].tm[i];
            trade_qty      = vecs[c].tq[i];
            trade_last     = (i == vecs[c].n - 1);
            while (!trade_ready && stall < 50) begin
                if (i == 0) stall++;
                @(negedge clk);
            end
            if (stall >= 50) begin
                checkOutput({vecs[c].name, "_ready_timeout"}, 128'(stall), 128'(HOLD + 1));
                trade_valid = 1'b0;
                return;
            end
            if (trade_last) exp_q.push_back(vecs[c]);
            @(negedge clk);
        end
        trade_valid = 1'b0;
        trade_last  = 1'b0;
        checkOutput({vecs[c].name, "_latency"}, 128'(frame_valid), 128'(1));
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!(trade_ready && !frame_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", 128'(n < 40), 128'(1));
    endtask

    // Scoreboard: pop on frame rise, track stability while high, check zero frame on fall.
    always @(negedge clk) begin
        if (reset && frame_valid && !prev_fv) begin
            checkOutput("frame_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                checkOutput({cur.name, "_position"}, 128'(position), 128'(cur.epos));
                checkOutput({cur.name, "_maturity"}, 128'(maturity), 128'(cur.emat));
                checkOutput({cur.name, "_err_full"}, 128'(err_full), 128'(cur.eful));
                checkOutput({cur.name, "_err_sat"},  128'(err_sat),  128'(cur.esat));
            end
            hold_len  = 1;
            stable_ok = 1'b1;
        end else if (reset && frame_valid) begin
            hold_len++;
            if (position !== cur.epos || maturity !== cur.emat || err_full !== cur.eful ||
                err_sat !== cur.esat || trade_ready !== 1'b0)
                stable_ok = 1'b0;
        end else if (reset && !frame_valid && prev_fv && !skip_fall) begin
            checkOutput({cur.name, "_hold_len"}, 128'(hold_len), 128'(HOLD));
            checkOutput({cur.name, "_hold_stable"}, 128'(stable_ok), 128'(1));
            checkOutput({cur.name, "_zero_frame"}, 128'(position == '0 && maturity == '0), 128'(1));
            checkOutput({cur.name, "_err_cleared"}, 128'({err_full, err_sat}), 128'(0));
            checkOutput({cur.name, "_clear_not_ready"}, 128'(trade_ready), 128'(0));
        end
        prev_fv = frame_valid;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stall;
        reset          = 1'b0;
        trade_valid    = 1'b0;
        trade_maturity = '0;
        trade_qty      = '0;
        trade_last     = 1'b0;

        vecs[0] = add(add(add(blank("net"), 8'd3, 16'd10), 8'd3, -16'sd4), 8'd7, -16'sd5);
        vecs[0].epos[0] = 16'd6;   vecs[0].emat[0] = 8'd3;
        vecs[0].epos[1] = -16'sd5; vecs[0].emat[1] = 8'd7;

        vecs[1] = blank("full");
        for (int i = 0; i < 9; i++) vecs[1] = add(vecs[1], 8'(i), 16'd1);
        for (int i = 0; i < SLOTS; i++) begin
            vecs[1].epos[i] = 16'd1;
            vecs[1].emat[i] = 8'(i);
        end
        vecs[1].eful = 1'b1;

        vecs[2] = add(add(blank("sat_pos"), 8'd2, 16'd30000), 8'd2, 16'd5000);
        vecs[2].epos[0] = 16'h7FFF; vecs[2].emat[0] = 8'd2; vecs[2].esat = 1'b1;

        vecs[3] = add(add(blank("sat_neg"), 8'd2, -16'sd30000), 8'd2, -16'sd5000);
        vecs[3].epos[0] = 16'h8001; vecs[3].emat[0] = 8'd2; vecs[3].esat = 1'b1;

        vecs[4] = add(add(blank("zero_net"), 8'd5, 16'd4), 8'd5, -16'sd4);
        vecs[4].epos[0] = 16'd0; vecs[4].emat[0] = 8'd5;

        vecs[5] = add(add(add(add(add(blank("mixed"), 8'd1, 16'd100), 8'd2, 16'd200),
                  8'd1, -16'sd50), 8'd3, 16'd7), 8'd2, -16'sd200);
        vecs[5].epos[0] = 16'd50; vecs[5].emat[0] = 8'd1;
        vecs[5].epos[1] = 16'd0;  vecs[5].emat[1] = 8'd2;
        vecs[5].epos[2] = 16'd7;  vecs[5].emat[2] = 8'd3;

        vecs[6] = add(add(add(blank("sat_sticky"), 8'd4, 16'd32767), 8'd4, 16'd1), 8'd4, -16'sd10);
        vecs[6].epos[0] = 16'h7FF5; vecs[6].emat[0] = 8'd4; vecs[6].esat = 1'b1;

        vecs[7] = add(blank("backpressure"), 8'd20, 16'd55);
        vecs[7].epos[0] = 16'd55; vecs[7].emat[0] = 8'd20;

        vecs[8] = add(blank("after_reset"), 8'd9, -16'sd123);
        vecs[8].epos[0] = -16'sd123; vecs[8].emat[0] = 8'd9;

        #3;
        checkOutput("reset_outputs", 128'({frame_valid, err_full, err_sat, position, maturity}), 128'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 128'(trade_ready), 128'(1));
        checkOutput("reset_idle_frame", 128'({frame_valid, position, maturity}), 128'(0));

        for (int c = 0; c < 7; c++) begin
            applyStimulus(c, stall);
            waitIdle();
        end

        $display("[TB] backpressure sequence");
        applyStimulus(0, stall);
        applyStimulus(7, stall);
        checkOutput("bp_stall_cycles", 128'(stall), 128'(HOLD + 1));
        waitIdle();

        $display("[TB] asynchronous reset sequence");
        applyStimulus(2, stall);
        repeat (2) @(negedge clk);
        #2;
        skip_fall = 1'b1;
        reset     = 1'b0;
        #1;
        checkOutput("async_reset_frame_valid", 128'(frame_valid), 128'(0));
        checkOutput("async_reset_outputs", 128'({position, maturity}), 128'(0));
        checkOutput("async_reset_errors", 128'({err_full, err_sat}), 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        skip_fall = 1'b0;
        checkOutput("post_reset_ready", 128'(trade_ready), 128'(1));
        applyStimulus(8, stall);
        waitIdle();
        checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/position_netting_loader.md
Name: position_netting_loader

Overview:
- Upstream feeder for the inter-month spread stage.
- Accepts a serial stream of trade records (contract maturity, signed quantity) for one portfolio and nets quantities that share a maturity into a fixed table of month slots.
- At end of portfolio, presents the netted table as the parallel position/maturity frame the spread stage consumes, holds it stable for its pipeline depth, then drives an all-zero frame so the spread stage sees the portfolio boundary.

Parameters:
- SLOTS, 8, number of contract-month slots; matches the spread stage's position/maturity arrays.
- QTY_W, 16, signed two's-complement quantity width.
- MAT_W, 8, maturity code width.
- HOLD_CYCLES, 8, cycles a netted frame is held stable on the outputs (covers the spread stage's pipeline).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- trade_valid  in  1  trade record valid.
- trade_ready  out  1  loader can accept a record this cycle.
- trade_maturity  in  MAT_W  maturity code of the trade.
- trade_qty  in  QTY_W  signed quantity; negative means short.
- trade_last  in  1  record is the last of the portfolio.
- position  out  QTY_W x SLOTS  netted signed position per slot.
- maturity  out  MAT_W x SLOTS  maturity code per slot.
- frame_valid  out  1  position/maturity hold a netted frame.
- err_full  out  1  sticky per frame; a trade needed a new slot while all slots were occupied.
- err_sat  out  1  sticky per frame; a slot sum saturated.

Behaviour:
- Reset (asynchronous, active-low):
  - state goes to COLLECT.
  - All table entries are cleared (occupied=0, mat=0, qty=0).
  - position, maturity, frame_valid, err_full and err_sat all go to 0.
  - hold counter goes to 0.
  - Reset asserted mid-frame or mid-collection discards all partial data.
- FSM states are COLLECT, PRESENT and CLEAR.
- COLLECT:
  - trade_ready=1. A record is accepted on a clk edge when trade_valid and trade_ready are both high.
  - Lookup is combinational: trade_maturity is compared against mat of every occupied slot. At most one slot can match.
  - On a hit, the slot's qty becomes the saturating sum of qty and trade_qty.
  - On a miss, the lowest-index unoccupied slot is allocated with that mat and qty=trade_qty.
  - On a miss with all slots occupied, the trade is dropped and err_full is set.
  - A slot whose net becomes 0 stays occupied.
  - Table update is visible on the cycle after acceptance.
  - If the accepted record has trade_last=1, next state is PRESENT. The output registers load from the post-update table on the same edge as the state change: occupied slots drive qty/mat, unoccupied slots drive 0/0.
  - frame_valid=1 from the first PRESENT cycle. Latency from last-record acceptance to frame_valid is 1 cycle.
- Saturation:
  - Sum is computed at QTY_W+1 bits.
  - Results above +32767 clamp to 16'h7FFF.
  - Results below -32767 clamp to 16'h8001, a symmetric range that keeps the magnitude representable for the downstream two's-complement negate.
  - Any clamp sets err_sat.
- PRESENT:
  - trade_ready=0; trade_valid is ignored.
  - Outputs are held constant.
  - Hold counter counts 0..HOLD_CYCLES-1, so frame_valid is high for exactly HOLD_CYCLES cycles; then next state is CLEAR.
- CLEAR (1 cycle):
  - position and maturity are driven to 0 and frame_valid=0.
  - Table is cleared; err_full and err_sat are cleared.
  - trade_ready=0. Next state is COLLECT.
  - The zero frame is therefore present for at least 1 cycle and stays until the next PRESENT.
- err_full and err_sat stay valid through PRESENT and are cleared in CLEAR.
- A portfolio of a single record with trade_last=1 is legal.
- An empty portfolio is impossible, since trade_last rides on a record.
- No sorting: slot order is allocation order. The downstream stage tiers each slot by maturity independently.

Decomposition:
- Shared package span_pkg holds:
  - SLOTS, QTY_W, MAT_W.
  - qty_t and mat_t typedefs.
  - slot_t struct {occupied, mat, qty}.
  - QTY_SAT_MAX=16'h7FFF and QTY_SAT_MIN=16'h8001.
  - state enum {COLLECT, PRESENT, CLEAR}.
- One sub-module, span_sat_add: a combinational signed saturating adder with a saturation flag, instanced once on the matched-or-allocated slot's sum path.

Test Plan:
- Netting:
  - Stimulus: trades (mat 3, +10), (mat 3, -4), (mat 7, -5, last).
  - Response: 1 cycle later frame_valid=1; slot0=(6, mat 3); slot1=(-5, mat 7); slots 2..7 = 0/0; held 8 cycles; then a zero frame with frame_valid=0.
- Full table:
  - Stimulus: 9 distinct maturities 0..8 with qty +1, last on the 9th.
  - Response: slots 0..7 hold mats 0..7 with qty 1; err_full=1 during PRESENT; cleared after CLEAR.
- Saturation:
  - Stimulus: (mat 2, +30000), (mat 2, +5000, last) → slot0=16'h7FFF, err_sat=1.
  - Stimulus: (mat 2, -30000), (mat 2, -5000, last) → slot0=16'h8001, err_sat=1.
- Backpressure:
  - Stimulus: trade_valid held high during PRESENT/CLEAR.
  - Response: trade_ready=0 for HOLD_CYCLES+1 cycles; no table change; the first record is accepted on the first COLLECT cycle.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during PRESENT cycle 3.
  - Response: outputs, frame_valid and errors drop to 0 immediately without a clock edge; after release, state is COLLECT with an empty table.
- Zero-net slot:
  - Stimulus: (mat 5, +4), (mat 5, -4, last).
  - Response: slot0=(0, mat 5), occupied; slots 1..7 = 0/0; frame_valid high 8 cycles.
